// File: rtl/emissor.sv
// Requester-side MSI coherence FSM for one cache block: turns each local CPU access
// into the next block state plus the bus message and write-back request, all registered (latency 1).
module emissor (
    input  logic       i_Clock,
    input  logic       i_Reset_n,
    input  logic [1:0] i_Operation,
    output logic [1:0] o_State,
    output logic [1:0] o_Message,
    output logic       o_Signal
);

    localparam logic [1:0] ST_INVALID  = 2'd0;
    localparam logic [1:0] ST_SHARED   = 2'd1;
    localparam logic [1:0] ST_MODIFIED = 2'd2;

    localparam logic [1:0] MSG_NONE       = 2'd0;
    localparam logic [1:0] MSG_READ_MISS  = 2'd1;
    localparam logic [1:0] MSG_WRITE_MISS = 2'd2;
    localparam logic [1:0] MSG_INVALIDATE = 2'd3;

    localparam logic [1:0] OP_RM = 2'b00;
    localparam logic [1:0] OP_RH = 2'b01;
    localparam logic [1:0] OP_WM = 2'b10;
    localparam logic [1:0] OP_WH = 2'b11;

    logic [1:0] r_State;
    logic [1:0] r_Message;
    logic       r_Signal;

    logic [1:0] next_state;
    logic [1:0] next_message;
    logic       next_signal;

    always_comb begin
        next_state   = ST_INVALID;
        next_message = MSG_NONE;
        next_signal  = 1'b0;
        case ({r_State, i_Operation})
            // A hit on an invalid block cannot really hit, so it behaves as the miss.
            {ST_INVALID, OP_RM},
            {ST_INVALID, OP_RH}: begin
                next_state   = ST_SHARED;
                next_message = MSG_READ_MISS;
            end
            {ST_INVALID, OP_WM},
            {ST_INVALID, OP_WH}: begin
                next_state   = ST_MODIFIED;
                next_message = MSG_WRITE_MISS;
            end
            {ST_SHARED, OP_RH}: begin
                next_state   = ST_SHARED;
                next_message = MSG_NONE;
            end
            {ST_SHARED, OP_RM}: begin
                next_state   = ST_SHARED;
                next_message = MSG_READ_MISS;
            end
            {ST_SHARED, OP_WH}: begin
                next_state   = ST_MODIFIED;
                next_message = MSG_INVALIDATE;
            end
            {ST_SHARED, OP_WM}: begin
                next_state   = ST_MODIFIED;
                next_message = MSG_WRITE_MISS;
            end
            {ST_MODIFIED, OP_RH},
            {ST_MODIFIED, OP_WH}: begin
                next_state   = ST_MODIFIED;
                next_message = MSG_NONE;
            end
            // Replacing a dirty block must flush it to memory first.
            {ST_MODIFIED, OP_RM}: begin
                next_state   = ST_SHARED;
                next_message = MSG_READ_MISS;
                next_signal  = 1'b1;
            end
            {ST_MODIFIED, OP_WM}: begin
                next_state   = ST_MODIFIED;
                next_message = MSG_WRITE_MISS;
                next_signal  = 1'b1;
            end
            default: begin
                next_state   = ST_INVALID;
                next_message = MSG_NONE;
                next_signal  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            r_State   <= ST_INVALID;
            r_Message <= MSG_NONE;
            r_Signal  <= 1'b0;
        end else begin
            r_State   <= next_state;
            r_Message <= next_message;
            r_Signal  <= next_signal;
        end
    end

    assign o_State   = r_State;
    assign o_Message = r_Message;
    assign o_Signal  = r_Signal;

endmodule

// File: tb/tb_emissor.sv
// Directed bench for emissor: hand-computed (state, message, signal) after each edge.
module tb_emissor;

    logic       i_Clock;
    logic       i_Reset_n;
    logic [1:0] i_Operation;
    logic [1:0] o_State;
    logic [1:0] o_Message;
    logic       o_Signal;

    int tests_run;
    int tests_failed;

    localparam logic [1:0] RM = 2'b00;
    localparam logic [1:0] RH = 2'b01;
    localparam logic [1:0] WM = 2'b10;
    localparam logic [1:0] WH = 2'b11;

    emissor dut (
        .i_Clock     (i_Clock),
        .i_Reset_n   (i_Reset_n),
        .i_Operation (i_Operation),
        .o_State     (o_State),
        .o_Message   (o_Message),
        .o_Signal    (o_Signal)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got state=%0d msg=%0d sig=%0d, expected state=%0d msg=%0d sig=%0d",
                     tag, got[4:3], got[2:1], got[0], exp[4:3], exp[2:1], exp[0]);
        end
    endtask

    // Drive on the negedge, sample 1 time unit after the next rising edge.
    task automatic step(input string tag, input logic rst_n, input logic [1:0] op,
                        input logic [1:0] es, input logic [1:0] em, input logic eg);
        @(negedge i_Clock);
        i_Reset_n   = rst_n;
        i_Operation = op;
        @(posedge i_Clock);
        #1;
        check(tag, {o_State, o_Message, o_Signal}, {es, em, eg});
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        i_Reset_n    = 1'b0;
        i_Operation  = RM;

        // Reset held for two edges
        @(posedge i_Clock);
        @(posedge i_Clock);
        #1;
        check("reset", {o_State, o_Message, o_Signal}, 5'b00_00_0);

        // Main sequence from INVALID
        step("I_RM", 1'b1, RM, 2'd1, 2'd1, 1'b0);
        step("S_RH", 1'b1, RH, 2'd1, 2'd0, 1'b0);
        step("S_RM", 1'b1, RM, 2'd1, 2'd1, 1'b0);
        step("S_WH", 1'b1, WH, 2'd2, 2'd3, 1'b0);
        step("M_WM", 1'b1, WM, 2'd2, 2'd2, 1'b1);

        // Repeated write misses in MODIFIED keep flushing
        for (int i = 0; i < 10; i++)
            step($sformatf("M_WM_hold%0d", i), 1'b1, WM, 2'd2, 2'd2, 1'b1);

        step("M_RM", 1'b1, RM, 2'd1, 2'd1, 1'b1);
        step("S_WM", 1'b1, WM, 2'd2, 2'd2, 1'b0);
        step("M_RH", 1'b1, RH, 2'd2, 2'd0, 1'b0);
        step("M_WH", 1'b1, WH, 2'd2, 2'd0, 1'b0);

        // Hits on INVALID act as misses
        step("rst_a", 1'b0, WM, 2'd0, 2'd0, 1'b0);
        step("I_RH", 1'b1, RH, 2'd1, 2'd1, 1'b0);
        step("rst_b", 1'b0, RH, 2'd0, 2'd0, 1'b0);
        step("I_WH", 1'b1, WH, 2'd2, 2'd2, 1'b0);

        // Reset beats a pending access mid-sequence
        step("M_WM_pre", 1'b1, WM, 2'd2, 2'd2, 1'b1);
        step("rst_mid", 1'b0, WM, 2'd0, 2'd0, 1'b0);
        step("I_WM", 1'b1, WM, 2'd2, 2'd2, 1'b0);
        step("M_WM_post", 1'b1, WM, 2'd2, 2'd2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
